program_counter_ctx: RTL
========================

Name: program_counter_ctx

Overview:
- Next-generation program counter for the single-issue core.
- Holds NCTX hardware process contexts, each with its own saved PC.
- Resolves branch/j/jr/halt/increment for the active context.
- Performs context switches at a commit boundary and counts a per-context execution quantum for the process scheduler.

Parameters:
- ADDR_W, 32: PC and jump-target width.
- NCTX, 4: number of contexts (power of two, 2..16); CTX_W = $clog2(NCTX).
- QUANTUM_W, 5: width of pc_counter.
- QUANTUM, 20: counted cycles before quantum_expired asserts (1..2^QUANTUM_W-1).
- RESET_PC, 0: reset value of PC and every saved PC.

Ports:
- Clock  in  1  core clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- j  in  1  unconditional jump.
- jr  in  1  jump register.
- branch  in  1  branch instruction.
- zero  in  1  ALU zero flag; branch is taken when branch && zero.
- AddressJump  in  ADDR_W  target for a taken branch, j, or jr.
- Halt  in  1  stall; PC holds when no jump is taken.
- exec_proc  in  1  quantum counting enabled (running a scheduled process).
- ctx_switch  in  1  switch to ctx_next this cycle.
- ctx_next  in  CTX_W  destination context.
- ctx_load  in  1  write pc_in into the saved PC of ctx_load_id.
- ctx_load_id  in  CTX_W  context written by ctx_load.
- pc_in  in  ADDR_W  value for ctx_load.
- pc_out  out  ADDR_W  instruction-memory address (the PC register).
- ctx_cur  out  CTX_W  active context.
- pc_counter  out  QUANTUM_W  counted cycles in the current quantum.
- quantum_expired  out  1  registered flag; high once pc_counter == QUANTUM.

Behaviour:
- Reset: PC = RESET_PC; every saved_pc[i] = RESET_PC; ctx_cur = 0; pc_counter = 0; quantum_expired = 0.
- Reset has priority over every other input.
- Taken signal: tk = (branch && zero) || j || jr.
- Next-PC (combinational): npc = AddressJump if tk; else PC if Halt; else PC+1.
  - PC+1 wraps modulo 2^ADDR_W.
- Advance: adv = tk || !Halt.
- Normal cycle (no ctx_switch):
  - PC <= npc.
  - If exec_proc && adv && pc_counter < QUANTUM: pc_counter += 1.
  - pc_counter saturates at QUANTUM.
- quantum_expired:
  - Set on the same edge that pc_counter becomes QUANTUM.
  - Stays high until a switch or reset.
- ctx_switch (the current instruction commits first):
  - saved_pc[ctx_cur] <= npc.
  - PC <= saved_pc[ctx_next].
  - ctx_cur <= ctx_next.
  - pc_counter <= 0; quantum_expired <= 0.
  - Latency: pc_out shows the new context's PC one cycle after ctx_switch is sampled.
- ctx_next == ctx_cur: PC <= npc (no stale-save read). Counter and flag are still cleared.
- ctx_load with no switch:
  - saved_pc[ctx_load_id] <= pc_in.
  - If ctx_load_id == ctx_cur, PC <= pc_in instead of npc, and pc_counter <= 0.
- ctx_load combined with ctx_switch:
  - ctx_load_id == ctx_next: PC <= pc_in (bypass).
  - ctx_load_id == ctx_cur (the old context): the load wins over the save; saved_pc[ctx_cur] <= pc_in.
- Simultaneous branch-taken and j/jr: all use AddressJump, so there is no conflict.
- Halt with tk: the jump is taken.
- Reset mid-switch: reset wins; no save occurs.

Optional Feature:
- Macro: PC_QUANTUM_AUTO_EN.
- Defined: when quantum_expired == 1 and ctx_switch == 0, the block performs an internal switch on that edge.
  - Target is (ctx_cur+1) mod NCTX.
  - Same save/restore and ctx_load rules as an explicit ctx_switch.
  - An explicit ctx_switch in the same cycle takes precedence.
- Not defined: quantum_expired is status only; switching happens solely via ctx_switch.

Test Plan:
- Reset, then 5 cycles with no controls and exec_proc=1 -> pc_out 0,1,2,3,4,5; pc_counter=5; ctx_cur=0.
- PC=7 with branch=1, zero=0 -> PC=8. Then branch=1, zero=1, AddressJump=0x40 -> PC=0x40. Then Halt=1 -> PC holds at 0x40 and pc_counter holds.
- ctx_load id=2, pc_in=0x100. Then ctx_switch, ctx_next=2, with PC=0x12 and j=1, AddressJump=0x30 -> pc_out=0x100, ctx_cur=2, pc_counter=0. A later switch back to context 0 -> pc_out=0x30.
- QUANTUM=20, exec_proc=1, free-running -> quantum_expired rises on the edge where pc_counter reaches 20. pc_counter stays at 20; both clear on ctx_switch.
- ctx_switch with ctx_next=3 plus ctx_load id=3, pc_in=0x200 in the same cycle -> pc_out=0x200. Assert Reset during a switch -> PC=RESET_PC and ctx_cur=0.
- PC_QUANTUM_AUTO_EN defined, ctx_cur=3, NCTX=4, quantum expires -> ctx_cur=0 next edge; saved_pc[3] holds the committed npc.

Source files
------------

// File: rtl/program_counter_ctx.sv
// rtl/program_counter_ctx.sv - multi-context program counter with per-context saved PC and execution quantum.
// Optional macro PC_QUANTUM_AUTO_EN: automatic round-robin switch when the quantum expires.
module program_counter_ctx #(
  parameter int ADDR_W    = 32,
  parameter int NCTX      = 4,
  parameter int QUANTUM_W = 5,
  parameter int QUANTUM   = 20,
  parameter int RESET_PC  = 0,
  parameter int CTX_W     = $clog2(NCTX)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 j,
  input  logic                 jr,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [ADDR_W-1:0]    AddressJump,
  input  logic                 Halt,
  input  logic                 exec_proc,
  input  logic                 ctx_switch,
  input  logic [CTX_W-1:0]     ctx_next,
  input  logic                 ctx_load,
  input  logic [CTX_W-1:0]     ctx_load_id,
  input  logic [ADDR_W-1:0]    pc_in,
  output logic [ADDR_W-1:0]    pc_out,
  output logic [CTX_W-1:0]     ctx_cur,
  output logic [QUANTUM_W-1:0] pc_counter,
  output logic                 quantum_expired
);

  localparam logic [ADDR_W-1:0]    PC_RST = ADDR_W'(RESET_PC);
  localparam logic [QUANTUM_W-1:0] Q_MAX  = QUANTUM_W'(QUANTUM);

  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    saved_pc [NCTX];

  logic                 tk;
  logic                 adv;
  logic [ADDR_W-1:0]    npc;
  logic                 do_switch;
  logic [CTX_W-1:0]     sw_tgt;
  logic                 load_hits_tgt;
  logic                 load_hits_cur;
  logic                 cnt_step;
  logic [ADDR_W-1:0]    pc_nxt;
  logic [CTX_W-1:0]     ctx_nxt;
  logic [QUANTUM_W-1:0] cnt_nxt;
  logic                 flag_nxt;

  always_comb begin
    tk  = (branch && zero) || j || jr;
    adv = tk || !Halt;
    if (tk)
      npc = AddressJump;
    else if (Halt)
      npc = pc_q;
    else
      npc = pc_q + ADDR_W'(1);
  end

  // An explicit request always beats the automatic round-robin target.
  always_comb begin
`ifdef PC_QUANTUM_AUTO_EN
    do_switch = ctx_switch || quantum_expired;
    sw_tgt    = ctx_switch ? ctx_next : ctx_cur + CTX_W'(1);
`else
    do_switch = ctx_switch;
    sw_tgt    = ctx_next;
`endif
    load_hits_tgt = ctx_load && (ctx_load_id == sw_tgt);
    load_hits_cur = ctx_load && (ctx_load_id == ctx_cur);
    cnt_step      = exec_proc && adv && (pc_counter < Q_MAX);
  end

  always_comb begin
    pc_nxt   = npc;
    ctx_nxt  = ctx_cur;
    cnt_nxt  = pc_counter;
    flag_nxt = quantum_expired;
    if (do_switch) begin
      ctx_nxt  = sw_tgt;
      cnt_nxt  = '0;
      flag_nxt = 1'b0;
      // Switching to self keeps the just-committed npc rather than the stale save.
      if (load_hits_tgt)
        pc_nxt = pc_in;
      else if (sw_tgt == ctx_cur)
        pc_nxt = npc;
      else
        pc_nxt = saved_pc[sw_tgt];
    end else if (load_hits_cur) begin
      pc_nxt  = pc_in;
      cnt_nxt = '0;
    end else if (cnt_step) begin
      cnt_nxt  = pc_counter + QUANTUM_W'(1);
      flag_nxt = quantum_expired || (cnt_nxt == Q_MAX);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q            <= PC_RST;
      ctx_cur         <= '0;
      pc_counter      <= '0;
      quantum_expired <= 1'b0;
      for (int i = 0; i < NCTX; i++)
        saved_pc[i] <= PC_RST;
    end else begin
      pc_q            <= pc_nxt;
      ctx_cur         <= ctx_nxt;
      pc_counter      <= cnt_nxt;
      quantum_expired <= flag_nxt;
      if (do_switch)
        saved_pc[ctx_cur] <= npc;
      // Ordered after the save so a load of the outgoing context wins.
      if (ctx_load)
        saved_pc[ctx_load_id] <= pc_in;
    end
  end

  assign pc_out = pc_q;

endmodule
